tm1637_display_arbiter: RTL and testbench
=========================================

# tm1637_display_arbiter

Shares one 4-digit TM1637 display between up to `N_REQ` requesters, e.g. the seconds counter, a debug value and a sensor readout. The block grants ownership round-robin with a guaranteed minimum on-screen time per owner. It drives the 16-bit packed-BCD `data` bus of `tm1637_external_connect` in the `clk25` domain. It replaces the hard-wired single-source connection at the top level.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, ≥2.
- `HOLD_CYCLES`, 25_000_000: minimum ownership time in `clk25` cycles (1 s), ≥1.
- `DEFAULT_DATA`, 16'h0000: `data_out` value after reset.

Ports:
- `clk25` in 1: the single clock, 25 MHz.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req` in `N_REQ`: level request, bit i = requester i.
- `data_in` in `16*N_REQ`: requester i at `[16*i+15:16*i]`, 4 BCD nibbles, digit 0 in `[3:0]`.
- `grant` out `N_REQ`: one-hot or zero, registered.
- `owner` out `$clog2(N_REQ)`: index of the last granted requester, registered.
- `busy` out 1: high when state ≠ IDLE.
- `data_out` out 16: connects to the display `data` input, registered.

## Operation
- States: IDLE, HOLD, ARB. Reset state is IDLE.
- **IDLE:**
  - `grant`=0; `data_out` holds its last value.
  - Any `req` bit set → round-robin pick, load `owner`, set `grant[owner]`, clear the hold counter, go to HOLD.
- **HOLD:**
  - `grant[owner]`=1.
  - While `req[owner]`=1, `data_out` ← `data_in[owner]` every cycle (live update).
  - While `req[owner]`=0, `data_out` is frozen and ownership is kept; there is no early release.
  - Counter increments each cycle. When the counter reaches `HOLD_CYCLES-1`, go to ARB.
- **ARB (exactly 1 cycle):**
  - `grant`=0 and `data_out` is frozen.
  - Round-robin pick over the `req` sampled in this cycle. The current owner may win again if it is the only requester.
  - Hit → new `owner`, HOLD, counter cleared. No hit → IDLE.
- **Round-robin pick:**
  - Search starts at `(owner+1) mod N_REQ` and wraps. The first set bit wins.
  - `owner` resets to `N_REQ-1`, so requester 0 has first priority after reset.
- Requests are never lost. A request arriving during another owner's HOLD is served at the next ARB.
- The hold counter is `$clog2(HOLD_CYCLES+1)` bits wide, unsigned, and clears on every entry into HOLD. It never wraps inside HOLD.
- `data_in` content is not checked. Nibbles >9 pass through unchanged.
- Reset values: `grant`=0, `owner`=`N_REQ-1`, `busy`=0, `data_out`=`DEFAULT_DATA`, counter=0.

## Timing
- `req` rising in IDLE at edge k → `grant` and `busy` high after edge k+1.
- `data_out` = `data_in[owner]` after edge k+2, then tracks `data_in` with 1-cycle latency.
- Ownership period is `HOLD_CYCLES` cycles of `grant` high, followed by 1 ARB cycle with `grant`=0.
- With `N_REQ` requesters continuously active, each requester returns every `N_REQ*(HOLD_CYCLES+1)` cycles.
- `rst_n` low forces all reset values immediately, with no clock needed; this includes mid-HOLD and ARB.
- Reset release is synchronised externally. The first pick happens on the first edge with `rst_n`=1.

## Structure
- Shared package `tm1637_pkg` holds:
  - `DIGITS`=4 and `DATA_W`=16.
  - The nibble-slice helper.
  - The arbiter state enum (IDLE/HOLD/ARB), reused by later display controllers.
- One combinational sub-module, `rr_pick`, with parameter `N`. Inputs: `req`, `last`. Outputs: `hit`, `idx`. Keeps the wrap-around search separately testable.
- The top module contains the FSM, the hold counter and the output registers.

## Test plan
All scenarios use `N_REQ`=4, `HOLD_CYCLES`=4.
- Reset: `rst_n`=0 with no clock → `grant`=0, `owner`=3, `busy`=0, `data_out`=16'h0000.
- Single requester: `req`=4'b0001, `data_in0`=16'h1234 at edge 0 → `grant`=0001 after edge 1 and `data_out`=1234 after edge 2. After 4 grant cycles, one ARB cycle with `grant`=0, then re-grant to 0.
- Full contention: `req`=4'b1111 with distinct values 16'h0001/0010/0100/1000 → `grant` sequence 0,1,2,3,0. Each lasts 4 cycles with a 1-cycle gap, and `data_out` follows the owner.
- Owner drop: requester 2 owns and drops `req` at hold cycle 1 with `data_out`=16'h0099 → `data_out` stays 0099 and `grant`=0100 until hold ends, then IDLE with `data_out` still 0099.
- Late arrival: `req[3]` rises exactly in the ARB cycle while owner=1 and `req[1]` stays set → 3 wins, since it is the first set bit in the 2→3→0→1 search.
- Async reset mid-HOLD: pulse `rst_n` low between edges → outputs return to reset values before the next edge, and the FSM restarts from IDLE.

Source files
------------

// File: rtl/tm1637_pkg.sv
// Shared definitions for TM1637 display blocks: digit geometry, arbiter
// state encoding and a helper for pulling one BCD digit out of a data word.
package tm1637_pkg;

  localparam int DIGITS = 4;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_ARB  = 2'd2
  } arb_state_t;

  function automatic logic [3:0] bcd_nibble(input logic [DATA_W-1:0] word,
                                            input int unsigned digit);
    return word[4*digit +: 4];
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set bit of req strictly after
// position last, wrapping; last itself is reached only at the end of the lap.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic                 hit,
  output logic [$clog2(N)-1:0] idx
);

  logic [$clog2(N)-1:0] w_cand;

  // Walk the lap backwards so the nearest candidate is written last and wins.
  always_comb begin
    hit    = |req;
    idx    = last;
    w_cand = last;
    for (int k = N; k >= 1; k--) begin
      w_cand = $clog2(N)'((int'(last) + k) % N);
      if (req[w_cand]) begin
        idx = w_cand;
      end
    end
  end

endmodule

// File: rtl/tm1637_display_arbiter.sv
// Round-robin owner of a shared 4-digit TM1637 display with a fixed minimum
// ownership time per grant and a one-cycle arbitration gap between owners.
import tm1637_pkg::*;

module tm1637_display_arbiter #(
  parameter int              N_REQ        = 4,
  parameter int              HOLD_CYCLES  = 25_000_000,
  parameter logic [DATA_W-1:0] DEFAULT_DATA = 16'h0000
) (
  input  logic                      clk25,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [DATA_W*N_REQ-1:0]   data_in,
  output logic [N_REQ-1:0]          grant,
  output logic [$clog2(N_REQ)-1:0]  owner,
  output logic                      busy,
  output logic [DATA_W-1:0]         data_out
);

  localparam int OW = $clog2(N_REQ);
  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_CYCLES - 1);

  arb_state_t          r_state, w_state_next;
  logic [CW-1:0]       r_cnt, w_cnt_next;
  logic [OW-1:0]       r_owner, w_owner_next;
  logic [N_REQ-1:0]    r_grant, w_grant_next;
  logic [DATA_W-1:0]   r_data, w_data_next;

  logic                w_hit;
  logic [OW-1:0]       w_idx;
  logic [DATA_W-1:0]   w_owner_word;
  logic [DATA_W-1:0]   w_owner_data;

  rr_pick #(.N(N_REQ)) u_pick (
    .req  (req),
    .last (r_owner),
    .hit  (w_hit),
    .idx  (w_idx)
  );

  assign w_owner_word = data_in[DATA_W*r_owner +: DATA_W];

  // Digits pass through untouched; non-decimal nibbles are the display's problem.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    assign w_owner_data[4*gi +: 4] = bcd_nibble(w_owner_word, gi);
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_owner_next = r_owner;
    w_grant_next = r_grant;
    w_data_next  = r_data;
    case (r_state)
      ST_IDLE, ST_ARB: begin
        w_grant_next = '0;
        w_state_next = ST_IDLE;
        if (w_hit) begin
          w_owner_next         = w_idx;
          w_grant_next[w_idx]  = 1'b1;
          w_cnt_next           = '0;
          w_state_next         = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // Ownership is kept for the full hold even if the owner lets go.
        if (req[r_owner]) begin
          w_data_next = w_owner_data;
        end
        if (r_cnt == CNT_LAST) begin
          w_grant_next = '0;
          w_state_next = ST_ARB;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: begin
        w_grant_next = '0;
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_owner <= OW'(N_REQ - 1);
      r_grant <= '0;
      r_data  <= DEFAULT_DATA;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_owner <= w_owner_next;
      r_grant <= w_grant_next;
      r_data  <= w_data_next;
    end
  end

  assign grant    = r_grant;
  assign owner    = r_owner;
  assign busy     = (r_state != ST_IDLE);
  assign data_out = r_data;

endmodule

// File: tb/tb_tm1637_display_arbiter.sv
// Scoreboard bench: a time-based ownership model predicts every cycle's
// outputs; a negedge monitor pops and compares them against the DUT.
module tb_tm1637_display_arbiter;

  localparam int N = 4;
  localparam int H = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req;
  logic [63:0]   data_in;
  logic [N-1:0]  grant;
  logic [1:0]    owner;
  logic          busy;
  logic [15:0]   data_out;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic [3:0]  grant;
    logic [1:0]  owner;
    logic        busy;
    logic [15:0] data;
  } exp_t;

  exp_t exp_q[$];

  // Model: an ownership lasts H clock edges, then one gap edge in which a
  // new winner is picked; idle and gap edges both just look for a winner.
  int          m_owner;
  bit          m_active;
  bit          m_arb;
  int          m_left;
  logic [15:0] m_data;

  tm1637_display_arbiter #(
    .N_REQ        (N),
    .HOLD_CYCLES  (H),
    .DEFAULT_DATA (16'h0000)
  ) dut (
    .clk25    (clk),
    .rst_n    (rst_n),
    .req      (req),
    .data_in  (data_in),
    .grant    (grant),
    .owner    (owner),
    .busy     (busy),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner  = N - 1;
      m_active = 0;
      m_arb    = 0;
      m_left   = 0;
      m_data   = 16'h0000;
      exp_q.delete();
    end else begin
      exp_t e;
      int   p;
      if (m_active) begin
        if (req[m_owner]) m_data = data_in[16*m_owner +: 16];
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_active = 0;
          m_arb    = 1;
        end
      end else begin
        p     = pick(req, m_owner);
        m_arb = 0;
        if (p >= 0) begin
          m_owner  = p;
          m_active = 1;
          m_left   = H;
        end
      end
      e.grant = m_active ? 4'(1 << m_owner) : 4'b0000;
      e.owner = 2'(m_owner);
      e.busy  = m_active || m_arb;
      e.data  = m_data;
      exp_q.push_back(e);
    end
  end

  always @(negedge clk) begin
    if (rst_n && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      cyc++;
      n_tests++;
      if (grant !== e.grant || owner !== e.owner || busy !== e.busy || data_out !== e.data) begin
        n_fail++;
        $display("FAIL sb cyc=%0d got g=%b o=%0d b=%b d=%h want g=%b o=%0d b=%b d=%h",
                 cyc, grant, owner, busy, data_out, e.grant, e.owner, e.busy, e.data);
      end else begin
        $display("[TB] cyc=%0d req=%b g=%b o=%0d b=%b d=%h ok",
                 cyc, req, grant, owner, busy, data_out);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end else begin
      $display("[TB] %s = %h ok", name, got);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_grant"}, 32'(grant), 32'h0);
    check({tag, "_owner"}, 32'(owner), 32'd3);
    check({tag, "_busy"},  32'(busy),  32'h0);
    check({tag, "_data"},  32'(data_out), 32'h0000);
  endtask

  task automatic wait_idle();
    int t;
    for (t = 0; t < 50; t++) begin
      @(negedge clk);
      if (!m_active && !m_arb) break;
    end
    if (t == 50) begin
      n_tests++; n_fail++;
      $display("FAIL wait_idle timeout");
    end
  endtask

  task automatic wait_owner(input int o, input bit in_gap);
    int t;
    for (t = 0; t < 50; t++) begin
      @(negedge clk);
      if (m_owner == o && (in_gap ? m_arb : m_active)) break;
    end
    if (t == 50) begin
      n_tests++; n_fail++;
      $display("FAIL wait_owner%0d timeout", o);
    end
  endtask

  initial begin
    req     = '0;
    data_in = '0;
    rst_n   = 1'b1;
    #1 rst_n = 1'b0;
    #1 check_reset_values("reset_noclk");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single requester with one re-grant.
    data_in[15:0] = 16'h1234;
    req = 4'b0001;
    repeat (12) @(negedge clk);
    req = 4'b0000;
    wait_idle();

    // Full contention, distinct values per requester.
    data_in = {16'h1000, 16'h0100, 16'h0010, 16'h0001};
    req = 4'b1111;
    repeat (25) @(negedge clk);
    req = 4'b0000;
    wait_idle();

    // Owner drops its request partway through the hold.
    data_in[47:32] = 16'h0099;
    req = 4'b0100;
    wait_owner(2, 1'b0);
    @(negedge clk);
    req = 4'b0000;
    data_in[47:32] = 16'h5555;
    check("drop_grant", 32'(grant), 32'h4);
    wait_idle();
    check("drop_idle_data", 32'(data_out), 32'h0099);
    check("drop_idle_busy", 32'(busy), 32'h0);

    // Late arrival in the gap cycle beats the continuing owner.
    req = 4'b0010;
    wait_owner(1, 1'b1);
    req = 4'b1010;
    @(negedge clk);
    check("late_owner", 32'(owner), 32'd3);
    check("late_grant", 32'(grant), 32'h8);
    req = 4'b0000;
    wait_idle();

    // Asynchronous reset in the middle of a hold.
    req = 4'b1111;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_values("reset_midhold");
    #1 rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Randomised traffic.
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) req = 4'($urandom_range(0, 15));
      data_in = {$urandom, $urandom};
    end
    req = 4'b0000;
    wait_idle();
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
